// File: rtl/s2p_pkg.sv
// Shared types and defaults for the S2P receive-frame controller.
// Holds the controller state encoding and the parameter defaults used by the top and its interface.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } rxState_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 40;

endpackage

// File: rtl/s2p_rx_ctrl_if.sv
// Control, receiver and output-stream signals of the S2P receive-frame controller.
// master = the controller itself, slave = the surrounding host/receiver/consumer side.
interface s2p_rx_ctrl_if import s2p_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  start;
    logic [CNT_WIDTH-1:0]  frame_len;
    logic                  abort;
    logic                  busy;
    logic                  frame_done;
    logic                  err_timeout;
    logic                  err_overrun;
    logic [CNT_WIDTH-1:0]  words_rcvd;
    logic                  s2p_receive;
    logic                  s2p_done;
    logic [DATA_WIDTH-1:0] s2p_data;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic [CW-1:0]         fifo_count;

    modport master (
        input  start, frame_len, abort, s2p_done, s2p_data, m_ready,
        output busy, frame_done, err_timeout, err_overrun, words_rcvd,
               s2p_receive, m_valid, m_data, fifo_count
    );

    modport slave (
        output start, frame_len, abort, s2p_done, s2p_data, m_ready,
        input  busy, frame_done, err_timeout, err_overrun, words_rcvd,
               s2p_receive, m_valid, m_data, fifo_count
    );

endinterface

// File: rtl/s2p_rx_ctrl_fifo.sv
// Small synchronous word FIFO, no fall-through: a push is visible at the head one cycle later.
// Push into a full FIFO is only taken when a pop happens in the same cycle; pop on empty is ignored.
module rx_word_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         pushData,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         popData,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic [CW-1:0]         cnt;
    logic                  doPush;
    logic                  doPop;

    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign doPop   = pop & ~empty;
    assign doPush  = push & (~full | doPop);
    assign popData = mem[rdPtr];
    assign count   = cnt;

    // Storage is cleared too so the head word reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/s2p_rx_ctrl.sv
// Frame controller: arms the S2P receiver once per word, queues words into an output FIFO, counts, flags timeout/overrun.
// Word reaches m_valid one cycle after s2p_done; a full FIFO without a same-cycle pop drops the word and flags overrun.
module s2p_rx_ctrl import s2p_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    s2p_rx_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    rxState_e                  state;
    logic [CNT_WIDTH-1:0]      lenQ;
    logic [CNT_WIDTH-1:0]      wordCnt;
    logic [CNT_WIDTH-1:0]      wordNext;
    logic [TW-1:0]             timer;
    logic                      busyQ;
    logic                      frameDoneQ;
    logic                      errTimeoutQ;
    logic                      errOverrunQ;
    logic                      receiveQ;

    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [$clog2(FIFO_DEPTH):0] fifoCount;
    logic [DATA_WIDTH-1:0]     headData;
    logic                      popNow;
    logic                      takeWord;
    logic                      overrun;

    assign popNow   = bus.m_ready & ~fifoEmpty;
    assign takeWord = (state == WAIT) & bus.s2p_done & ~bus.abort;
    assign overrun  = takeWord & fifoFull & ~popNow;
    assign wordNext = (wordCnt == '1) ? wordCnt : wordCnt + CNT_WIDTH'(1);

    rx_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (takeWord & ~overrun),
        .pushData (bus.s2p_data),
        .pop      (popNow),
        .popData  (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Pulse outputs are set on the transition into their state so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            lenQ        <= '0;
            wordCnt     <= '0;
            timer       <= '0;
            busyQ       <= 1'b0;
            frameDoneQ  <= 1'b0;
            errTimeoutQ <= 1'b0;
            errOverrunQ <= 1'b0;
            receiveQ    <= 1'b0;
        end else begin
            frameDoneQ <= 1'b0;
            receiveQ   <= 1'b0;
            if (bus.abort && state != IDLE) begin
                state <= IDLE;
                busyQ <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            lenQ        <= bus.frame_len;
                            errTimeoutQ <= 1'b0;
                            errOverrunQ <= 1'b0;
                            wordCnt     <= '0;
                            busyQ       <= 1'b1;
                            if (bus.frame_len != '0) begin
                                state    <= ARM;
                                receiveQ <= 1'b1;
                            end else begin
                                state      <= DONE;
                                frameDoneQ <= 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        timer <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // A done arriving on the expiry cycle still counts as a good word.
                        if (bus.s2p_done) begin
                            wordCnt <= wordNext;
                            if (overrun) begin
                                errOverrunQ <= 1'b1;
                            end
                            if (wordNext == lenQ) begin
                                state      <= DONE;
                                frameDoneQ <= 1'b1;
                            end else begin
                                state    <= ARM;
                                receiveQ <= 1'b1;
                            end
                        end else if (timer == TIMER_LAST) begin
                            errTimeoutQ <= 1'b1;
                            state       <= DONE;
                            frameDoneQ  <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busyQ <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busyQ <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busyQ;
    assign bus.frame_done  = frameDoneQ;
    assign bus.err_timeout = errTimeoutQ;
    assign bus.err_overrun = errOverrunQ;
    assign bus.words_rcvd  = wordCnt;
    assign bus.s2p_receive = receiveQ;
    assign bus.m_valid     = ~fifoEmpty;
    assign bus.m_data      = headData;
    assign bus.fifo_count  = fifoCount;

endmodule

// File: tb/tb_s2p_rx_ctrl.sv
// Directed bench for s2p_rx_ctrl: per-cycle vector table for a normal frame and IDLE corners,
// then hand-written sequences for timeout, overrun, full-FIFO pop, abort and mid-frame reset.
module tb_s2p_rx_ctrl;

    localparam int DW  = 16;
    localparam int CNW = 8;
    localparam int FD  = 4;
    localparam int TO  = 40;

    logic clk;
    logic reset;

    int nChecks = 0;
    int nFails  = 0;

    s2p_rx_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CNW), .FIFO_DEPTH(FD)) bus ();

    s2p_rx_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CNW),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          abort;
        logic [7:0]    len;
        logic          done;
        logic [15:0]   data;
        logic          mReady;
        logic          busy;
        logic          fdone;
        logic          recv;
        logic          mValid;
        logic [15:0]   mData;
        logic [2:0]    cnt;
        logic [7:0]    words;
        logic          errT;
        logic          errO;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Receiver stand-in: waits for the arm pulse, then returns one word two cycles later.
    task automatic serveWord(input logic [15:0] d, input logic mr);
        int n = 0;
        while (!bus.s2p_receive && n < 20) begin
            step();
            n++;
        end
        if (!bus.s2p_receive) begin
            nChecks++;
            nFails++;
            $display("FAIL serve_wait: s2p_receive never rose (waited %0d cycles)", n);
        end else begin
            step();
            bus.s2p_done = 1'b1;
            bus.s2p_data = d;
            bus.m_ready  = mr;
            step();
            bus.s2p_done = 1'b0;
            bus.s2p_data = '0;
            bus.m_ready  = 1'b0;
        end
    endtask

    function automatic logic [32:0] observe();
        return {bus.busy, bus.frame_done, bus.s2p_receive, bus.m_valid,
                (bus.m_valid ? bus.m_data : 16'h0), bus.fifo_count, bus.words_rcvd,
                bus.err_timeout, bus.err_overrun};
    endfunction

    function automatic logic [32:0] expected(input vec_t v);
        return {v.busy, v.fdone, v.recv, v.mValid, v.mData, v.cnt, v.words, v.errT, v.errO};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] drainExp [4];

        // start abort len done data mRdy | busy fdone recv mValid mData cnt words errT errO
        vecs.push_back('{1'b1, 1'b0, 8'd3, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'd1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1, 8'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5678, 3'd1, 8'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 16'h9ABC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h9ABC, 3'd1, 8'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd3, 1'b0, 1'b0});
        // zero-length frame, then a stray done in IDLE, then abort beating start
        vecs.push_back('{1'b1, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'd0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'd2, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 8'd0, 1'b0, 1'b0});

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.frame_len = '0;
        bus.s2p_done  = 1'b0;
        bus.s2p_data  = '0;
        bus.m_ready   = 1'b0;
        step();
        step();
        check("reset_state", {bus.busy, bus.frame_done, bus.err_timeout, bus.err_overrun, bus.words_rcvd,
                              bus.s2p_receive, bus.m_valid, bus.m_data, bus.fifo_count}, '0);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            bus.start     = vecs[i].start;
            bus.abort     = vecs[i].abort;
            bus.frame_len = vecs[i].len;
            bus.s2p_done  = vecs[i].done;
            bus.s2p_data  = vecs[i].data;
            bus.m_ready   = vecs[i].mReady;
            step();
            check($sformatf("vec%0d", i), observe(), expected(vecs[i]));
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.frame_len = '0;
        bus.s2p_done = 1'b0; bus.s2p_data = '0; bus.m_ready = 1'b0;

        // Timeout: receiver stays silent.
        bus.start = 1'b1; bus.frame_len = 8'd2;
        step();
        bus.start = 1'b0;
        check("to_arm_pulse", bus.s2p_receive, 1'b1);
        step();
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_done && n < 100);
        check("to_cycles_in_wait", n, TO);
        check("to_err_timeout", bus.err_timeout, 1'b1);
        check("to_words_rcvd", bus.words_rcvd, 8'd0);
        step();
        check("to_busy_drop", bus.busy, 1'b0);
        bus.start = 1'b1; bus.frame_len = 8'd0;
        step();
        bus.start = 1'b0;
        check("to_err_cleared", bus.err_timeout, 1'b0);
        step();

        // Overrun: consumer stalled, six words into a four-deep FIFO.
        bus.start = 1'b1; bus.frame_len = 8'd6;
        step();
        bus.start = 1'b0;
        for (int w = 0; w < 6; w++) begin
            serveWord(16'hA000 + 16'(w), 1'b0);
            if (w == 3) begin
                check("ov_count_full", bus.fifo_count, 3'd4);
                check("ov_no_err_yet", bus.err_overrun, 1'b0);
            end
            if (w == 4) begin
                check("ov_err_set", bus.err_overrun, 1'b1);
                check("ov_count_held", bus.fifo_count, 3'd4);
            end
        end
        check("ov_words_rcvd", bus.words_rcvd, 8'd6);
        check("ov_frame_done", bus.frame_done, 1'b1);
        step();
        check("ov_head_oldest", {bus.m_valid, bus.m_data}, {1'b1, 16'hA000});

        // Full FIFO with a pop on the same cycle as the incoming word.
        bus.start = 1'b1; bus.frame_len = 8'd1;
        step();
        bus.start = 1'b0;
        serveWord(16'hBEEF, 1'b1);
        check("fp_count_stays", bus.fifo_count, 3'd4);
        check("fp_no_overrun", bus.err_overrun, 1'b0);
        check("fp_frame_done", bus.frame_done, 1'b1);
        step();

        drainExp[0] = 16'hA001;
        drainExp[1] = 16'hA002;
        drainExp[2] = 16'hA003;
        drainExp[3] = 16'hBEEF;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), {bus.m_valid, bus.m_data}, {1'b1, drainExp[k]});
            step();
        end
        bus.m_ready = 1'b0;
        check("drain_empty", {bus.m_valid, bus.fifo_count}, 4'd0);

        // Abort while waiting for word 2.
        bus.start = 1'b1; bus.frame_len = 8'd3;
        step();
        bus.start = 1'b0;
        serveWord(16'h1111, 1'b0);
        step();
        step();
        check("ab_busy_before", bus.busy, 1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("ab_idle", {bus.busy, bus.frame_done}, 2'b00);
        check("ab_fifo_kept", {bus.fifo_count, bus.m_valid, bus.m_data}, {3'd1, 1'b1, 16'h1111});
        step();
        check("ab_no_done_later", {bus.busy, bus.frame_done}, 2'b00);

        // Reset in the middle of a frame.
        bus.start = 1'b1; bus.frame_len = 8'd3;
        step();
        bus.start = 1'b0;
        serveWord(16'h2222, 1'b0);
        step();
        check("rs_before", {bus.busy, bus.fifo_count, bus.words_rcvd}, {1'b1, 3'd2, 8'd1});
        reset = 1'b0;
        step();
        check("rs_all_zero", {bus.busy, bus.frame_done, bus.err_timeout, bus.err_overrun, bus.words_rcvd,
                              bus.s2p_receive, bus.m_valid, bus.m_data, bus.fifo_count}, '0);
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
